id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register between decode and the ALU of the 5-stage RV32I core.
- Captures decoded operands and controls, and stalls on load-use hazards by inserting a bubble.
- Applies MEM/WB forwarding and drives the ALU inputs ex_src_a, ex_src_b and ex_alu_ctrl.
- Also passes store data and memory/writeback controls to EX/MEM.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill the EX slot (branch/jump redirect).
- ex_hold  in  1  downstream stall; freeze the EX slot.
- id_valid  in  1  decode slot holds an instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_val, id_rs2_val  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices.
- id_alu_ctrl  in  4  ALU operation code (shared ALU encoding).
- id_a_sel  in  2  A source: 00 reg, 01 pc, 10 zero; 11 treated as zero.
- id_b_sel  in  1  B source: 0 reg, 1 imm.
- id_reg_write, id_mem_read, id_mem_write  in  1  decode controls.
- mem_fwd_valid  in  1  MEM-stage forwarding source valid.
- mem_fwd_rd  in  REG_AW  MEM-stage destination.
- mem_fwd_data  in  XLEN  MEM-stage result.
- wb_fwd_valid  in  1  WB-stage forwarding source valid.
- wb_fwd_rd  in  REG_AW  WB-stage destination.
- wb_fwd_data  in  XLEN  WB-stage result.
- id_stall  out  1  hold IF/ID this cycle (combinational).
- ex_valid  out  1  EX slot valid.
- ex_pc  out  XLEN  registered PC.
- ex_src_a, ex_src_b  out  XLEN  ALU operands after forwarding.
- ex_alu_ctrl  out  4  registered ALU operation code.
- ex_store_data  out  XLEN  forwarded rs2 value.
- ex_rd  out  REG_AW  registered destination.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls.

Behaviour:
- Reset values: all registered outputs 0 (ex_valid=0, ex_alu_ctrl=ADD). id_stall=0 during reset.
- Source usage: uses_rs1 = (id_a_sel==00). uses_rs2 = (id_b_sel==0) | id_mem_write.
- Load-use hazard: lu = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- id_stall = lu | ex_hold.
- Per-edge priority: reset > flush > ex_hold > lu > load.
  - flush: ex_valid=0 and all controls 0; the id_* inputs are not captured. Flush overrides ex_hold.
  - ex_hold: all fields keep their values, except the stored rs1/rs2 values are refreshed with the resolved forwarded value, so a producer retiring during the hold is not lost.
  - lu: insert a bubble (valid=0, reg_write/mem_* = 0). The instruction stays in ID and is captured next cycle with the value forwarded from MEM.
  - load: capture every id_* field. ex_valid=id_valid. When id_valid=0, controls are zeroed.
- Capture bypass: if wb_fwd_valid & wb_fwd_rd!=0 & wb_fwd_rd==id_rsN, store wb_fwd_data instead of id_rsN_val.
- Forwarding, combinational on registered rsN: MEM match wins over WB match, which wins over the stored value. x0 is never forwarded (rd==0 ignored).
- ex_src_a = fwd_rs1 / ex_pc / 0 per the registered a_sel.
- ex_src_b = fwd_rs2 or registered imm per the registered b_sel.
- ex_store_data = fwd_rs2 always.
- Latency: 1 cycle from decode to the ALU inputs. A load-use costs exactly 1 bubble.
- Back-to-back lu cannot occur, because the bubble clears ex_mem_read.
- Reset mid-hold clears the slot; the held instruction is lost and refetch is the front end's responsibility.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- When defined, adds outputs stat_bubbles[31:0] and stat_flushes[31:0].
  - stat_bubbles increments on each edge where lu is taken (not masked by flush or ex_hold).
  - stat_flushes increments on each flush edge.
  - Both counters wrap at 2^32 and reset to 0.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - ALU opcode constants (ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, SHL 1000, SHR 1010, SHA 1011, SLT 1100, SLTU 1101, A 0111, B 1111).
  - A_SEL_REG/PC/ZERO and B_SEL_REG/IMM.
  - XLEN and REG_AW.
- Sub-module fwd_mux: pure combinational MEM/WB/stored select with the x0 guard. Instantiated twice (rs1, rs2).

Test Plan:
1. Basic add: addi x1,x0,5 (a_sel=10, b_sel=1, imm=5, ALU_ADD) -> next cycle ex_valid=1, ex_src_a=0, ex_src_b=5, ex_alu_ctrl=0000, ex_rd=1.
2. Forward priority: EX has rs1=3 stored 0x11; mem_fwd rd=3 data 0x22; wb_fwd rd=3 data 0x33 -> ex_src_a=0x22. With mem_fwd_valid=0 -> 0x33. With rd=0 on both -> 0x11.
3. Load-use: lw x5 in EX (mem_read=1, rd=5); ID add uses rs1=5 -> id_stall=1 and bubble (ex_valid=0). Next cycle add is captured and ex_src_a equals mem_fwd_data 0xDEAD with mem_fwd_rd=5.
4. Flush with ex_hold=1 and id_valid=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0 on the next edge.
5. Hold refresh: hold 3 cycles while the MEM producer for rs2 moves to WB and then retires -> ex_src_b stays 0x7 throughout and after release.
6. Under ID_EX_STATS_EN: 2 load-use events plus 1 flush -> stat_bubbles=2, stat_flushes=1. Reset -> both 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: widths, ALU opcodes, operand selects and the ID/EX payload.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned ASEL_W = 2;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_A    = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SHL  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SHR  = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_SHA  = 4'b1011;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1101;
    localparam logic [ALU_W-1:0] ALU_B    = 4'b1111;

    localparam logic [ASEL_W-1:0] A_SEL_REG  = 2'b00;
    localparam logic [ASEL_W-1:0] A_SEL_PC   = 2'b01;
    localparam logic [ASEL_W-1:0] A_SEL_ZERO = 2'b10;

    localparam logic B_SEL_REG = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    // Contents of the EX slot held between decode and the ALU.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [ALU_W-1:0]  alu_ctrl;
        logic [ASEL_W-1:0] a_sel;
        logic              b_sel;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: MEM result over WB result over stored value; x0 never forwarded.
module fwd_mux
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   stored_val,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_val_c
);

    // Youngest matching producer wins.
    always_comb begin
        fwd_val_c = stored_val;
        if (mem_valid && (mem_rd != '0) && (mem_rd == rs)) begin
            fwd_val_c = mem_data;
        end else if (wb_valid && (wb_rd != '0) && (wb_rd == rs)) begin
            fwd_val_c = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and MEM/WB operand forwarding.
// Optional macro ID_EX_STATS_EN adds stat_bubbles / stat_flushes event counters.
module id_ex_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_val,
    input  logic [XLEN-1:0]   id_rs2_val,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [ALU_W-1:0]  id_alu_ctrl,
    input  logic [ASEL_W-1:0] id_a_sel,
    input  logic              id_b_sel,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              mem_fwd_valid,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_valid,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_src_a,
    output logic [XLEN-1:0]   ex_src_b,
    output logic [ALU_W-1:0]  ex_alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]       stat_bubbles,
    output logic [31:0]       stat_flushes
`endif
);

    id_ex_t          ex_q;
    id_ex_t          cap_c;
    logic            uses_rs1_c;
    logic            uses_rs2_c;
    logic            lu_c;
    logic [XLEN-1:0] fwd_rs1_c;
    logic [XLEN-1:0] fwd_rs2_c;

    // Load-use detection against the load currently sitting in EX.
    always_comb begin
        uses_rs1_c = (id_a_sel == A_SEL_REG);
        uses_rs2_c = (id_b_sel == B_SEL_REG) | id_mem_write;
        lu_c = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
               ((uses_rs1_c & (id_rs1 == ex_q.rd)) | (uses_rs2_c & (id_rs2 == ex_q.rd)));
    end

    assign id_stall = ~reset & (lu_c | ex_hold);

    // Payload presented by decode, with the WB result bypassed over the register file read.
    always_comb begin
        cap_c           = '0;
        cap_c.valid     = id_valid;
        cap_c.pc        = id_pc;
        cap_c.rs1_val   = id_rs1_val;
        cap_c.rs2_val   = id_rs2_val;
        cap_c.imm       = id_imm;
        cap_c.rs1       = id_rs1;
        cap_c.rs2       = id_rs2;
        cap_c.rd        = id_rd;
        cap_c.alu_ctrl  = id_alu_ctrl;
        cap_c.a_sel     = id_a_sel;
        cap_c.b_sel     = id_b_sel;
        cap_c.reg_write = id_valid & id_reg_write;
        cap_c.mem_read  = id_valid & id_mem_read;
        cap_c.mem_write = id_valid & id_mem_write;
        if (wb_fwd_valid && (wb_fwd_rd != '0) && (wb_fwd_rd == id_rs1)) begin
            cap_c.rs1_val = wb_fwd_data;
        end
        if (wb_fwd_valid && (wb_fwd_rd != '0) && (wb_fwd_rd == id_rs2)) begin
            cap_c.rs2_val = wb_fwd_data;
        end
    end

    // EX slot update: reset > flush > hold (refresh operands) > bubble > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
        end else if (ex_hold) begin
            ex_q.rs1_val <= fwd_rs1_c;
            ex_q.rs2_val <= fwd_rs2_c;
        end else if (lu_c) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
        end else begin
            ex_q <= cap_c;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs         (ex_q.rs1),
        .stored_val (ex_q.rs1_val),
        .mem_valid  (mem_fwd_valid),
        .mem_rd     (mem_fwd_rd),
        .mem_data   (mem_fwd_data),
        .wb_valid   (wb_fwd_valid),
        .wb_rd      (wb_fwd_rd),
        .wb_data    (wb_fwd_data),
        .fwd_val_c  (fwd_rs1_c)
    );

    fwd_mux u_fwd_rs2 (
        .rs         (ex_q.rs2),
        .stored_val (ex_q.rs2_val),
        .mem_valid  (mem_fwd_valid),
        .mem_rd     (mem_fwd_rd),
        .mem_data   (mem_fwd_data),
        .wb_valid   (wb_fwd_valid),
        .wb_rd      (wb_fwd_rd),
        .wb_data    (wb_fwd_data),
        .fwd_val_c  (fwd_rs2_c)
    );

    // ALU operand selection from the registered selects.
    always_comb begin
        ex_src_a = '0;
        case (ex_q.a_sel)
            A_SEL_REG: ex_src_a = fwd_rs1_c;
            A_SEL_PC:  ex_src_a = ex_q.pc;
            default:   ex_src_a = '0;
        endcase
        ex_src_b = (ex_q.b_sel == B_SEL_IMM) ? ex_q.imm : fwd_rs2_c;
    end

    assign ex_store_data = fwd_rs2_c;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

`ifdef ID_EX_STATS_EN
    // Count taken load-use bubbles and flushes; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_bubbles <= '0;
            stat_flushes <= '0;
        end else begin
            if (flush) begin
                stat_flushes <= stat_flushes + 32'(1);
            end
            if (!flush && !ex_hold && lu_c) begin
                stat_bubbles <= stat_bubbles + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of expected EX-slot values per clock edge.
module tb_id_ex_stage;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              ex_hold;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_val;
    logic [XLEN-1:0]   id_rs2_val;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [ALU_W-1:0]  id_alu_ctrl;
    logic [ASEL_W-1:0] id_a_sel;
    logic              id_b_sel;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              mem_fwd_valid;
    logic [REG_AW-1:0] mem_fwd_rd;
    logic [XLEN-1:0]   mem_fwd_data;
    logic              wb_fwd_valid;
    logic [REG_AW-1:0] wb_fwd_rd;
    logic [XLEN-1:0]   wb_fwd_data;
    logic              id_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_src_a;
    logic [XLEN-1:0]   ex_src_b;
    logic [ALU_W-1:0]  ex_alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
`ifdef ID_EX_STATS_EN
    logic [31:0]       stat_bubbles;
    logic [31:0]       stat_flushes;
`endif

    typedef enum int {O_VALID, O_PC, O_SRC_A, O_SRC_B, O_ALU, O_STORE, O_RD, O_RW, O_MR, O_MW} obs_e;
    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .ex_hold       (ex_hold),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_val    (id_rs1_val),
        .id_rs2_val    (id_rs2_val),
        .id_imm        (id_imm),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_alu_ctrl   (id_alu_ctrl),
        .id_a_sel      (id_a_sel),
        .id_b_sel      (id_b_sel),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_fwd_rd     (wb_fwd_rd),
        .wb_fwd_data   (wb_fwd_data),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_src_a      (ex_src_a),
        .ex_src_b      (ex_src_b),
        .ex_alu_ctrl   (ex_alu_ctrl),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write)
`ifdef ID_EX_STATS_EN
        ,
        .stat_bubbles  (stat_bubbles),
        .stat_flushes  (stat_flushes)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input obs_e sel);
        case (sel)
            O_VALID: return 32'(ex_valid);
            O_PC:    return ex_pc;
            O_SRC_A: return ex_src_a;
            O_SRC_B: return ex_src_b;
            O_ALU:   return 32'(ex_alu_ctrl);
            O_STORE: return ex_store_data;
            O_RD:    return 32'(ex_rd);
            O_RW:    return 32'(ex_reg_write);
            O_MR:    return 32'(ex_mem_read);
            default: return 32'(ex_mem_write);
        endcase
    endfunction

    task automatic expect_out(input string tag, input obs_e sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // One clock edge, then drain the scoreboard against the registered EX slot.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic idle();
        flush = 0; ex_hold = 0; id_valid = 0; id_pc = '0;
        id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_ctrl = ALU_ADD;
        id_a_sel = A_SEL_REG; id_b_sel = B_SEL_REG;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_fwd_valid = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_fwd_valid = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
    endtask

    initial begin
        reset = 1;
        idle();
        ex_hold = 1;
        #1 check_eq("stall_in_reset", 32'(id_stall), 32'h0);
        expect_out("rst_valid", O_VALID, 0);
        expect_out("rst_alu", O_ALU, 32'(ALU_ADD));
        expect_out("rst_rw", O_RW, 0);
        expect_out("rst_mr", O_MR, 0);
        expect_out("rst_pc", O_PC, 0);
        step();
`ifdef ID_EX_STATS_EN
        check_eq("rst_stat_bub", stat_bubbles, 0);
        check_eq("rst_stat_fl", stat_flushes, 0);
`endif
        reset = 0;

        // addi x1, x0, 5
        idle();
        id_valid = 1; id_a_sel = A_SEL_ZERO; id_b_sel = B_SEL_IMM; id_imm = 32'd5;
        id_alu_ctrl = ALU_ADD; id_rd = 5'd1; id_reg_write = 1;
        expect_out("addi_valid", O_VALID, 1);
        expect_out("addi_a", O_SRC_A, 0);
        expect_out("addi_b", O_SRC_B, 5);
        expect_out("addi_alu", O_ALU, 32'(ALU_ADD));
        expect_out("addi_rd", O_RD, 1);
        step();

        // auipc-like: A from PC
        idle();
        id_valid = 1; id_pc = 32'h100; id_a_sel = A_SEL_PC; id_b_sel = B_SEL_IMM;
        id_imm = 32'd8; id_alu_ctrl = ALU_SUB; id_rd = 5'd2;
        expect_out("pc_a", O_SRC_A, 32'h100);
        expect_out("pc_b", O_SRC_B, 8);
        expect_out("pc_alu", O_ALU, 32'(ALU_SUB));
        step();

        // Forward priority on stored rs1=3 (0x11)
        idle();
        id_valid = 1; id_a_sel = A_SEL_REG; id_rs1 = 5'd3; id_rs1_val = 32'h11;
        id_rs2 = 5'd0; id_rs2_val = 32'h99; id_b_sel = B_SEL_IMM; id_rd = 5'd4;
        step();
        idle();
        mem_fwd_valid = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h22;
        wb_fwd_valid = 1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'h33;
        #1 check_eq("fwd_mem_wins", ex_src_a, 32'h22);
        mem_fwd_valid = 0;
        #1 check_eq("fwd_wb", ex_src_a, 32'h33);
        mem_fwd_valid = 1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        #1 check_eq("fwd_x0_guard", ex_src_a, 32'h11);
        check_eq("store_x0", ex_store_data, 32'h99);

        // Capture bypass from WB, and x0 excluded from bypass
        idle();
        id_valid = 1; id_a_sel = A_SEL_REG; id_rs1 = 5'd9; id_rs1_val = 32'h1;
        id_b_sel = B_SEL_IMM; wb_fwd_valid = 1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'h44;
        step();
        wb_fwd_valid = 0;
        #1 check_eq("cap_bypass", ex_src_a, 32'h44);
        idle();
        id_valid = 1; id_a_sel = A_SEL_REG; id_rs1 = 5'd0; id_rs1_val = 32'h5;
        id_b_sel = B_SEL_IMM; wb_fwd_valid = 1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'h66;
        step();
        check_eq("cap_x0", ex_src_a, 32'h5);

        // Load with rd=0 in EX never stalls
        idle();
        id_valid = 1; id_mem_read = 1; id_rd = 5'd0; id_a_sel = A_SEL_REG; id_b_sel = B_SEL_IMM;
        step();
        idle();
        id_valid = 1; id_a_sel = A_SEL_REG; id_rs1 = 5'd0; id_b_sel = B_SEL_IMM;
        #1 check_eq("lu_rd0_nostall", 32'(id_stall), 0);
        expect_out("lu_rd0_valid", O_VALID, 1);
        step();

        // Load-use on rs1: lw x5 then add using x5
        idle();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd5;
        id_a_sel = A_SEL_REG; id_b_sel = B_SEL_IMM;
        expect_out("lw_mr", O_MR, 1);
        expect_out("lw_rd", O_RD, 5);
        step();
        idle();
        id_valid = 1; id_a_sel = A_SEL_REG; id_rs1 = 5'd5; id_b_sel = B_SEL_IMM;
        id_imm = 32'd1; id_rd = 5'd6; id_reg_write = 1;
        #1 check_eq("lu_stall", 32'(id_stall), 1);
        expect_out("lu_bubble_valid", O_VALID, 0);
        expect_out("lu_bubble_rw", O_RW, 0);
        expect_out("lu_bubble_mr", O_MR, 0);
        step();
        check_eq("lu_stall_clear", 32'(id_stall), 0);
        mem_fwd_valid = 1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'hDEAD;
        expect_out("lu_cap_valid", O_VALID, 1);
        expect_out("lu_cap_a", O_SRC_A, 32'hDEAD);
        expect_out("lu_cap_b", O_SRC_B, 1);
        expect_out("lu_cap_rd", O_RD, 6);
        step();

        // Flush overrides hold
        idle();
        flush = 1; ex_hold = 1; id_valid = 1; id_reg_write = 1; id_mem_write = 1;
        expect_out("flush_valid", O_VALID, 0);
        expect_out("flush_rw", O_RW, 0);
        expect_out("flush_mw", O_MW, 0);
        step();

        // Hold refresh: rs2 producer moves MEM -> WB -> retired during a 3-cycle hold
        idle();
        id_valid = 1; id_a_sel = A_SEL_ZERO; id_b_sel = B_SEL_REG; id_rs2 = 5'd7;
        id_rs2_val = 32'h0; id_rd = 5'd8; id_reg_write = 1;
        step();
        idle();
        ex_hold = 1; mem_fwd_valid = 1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h7;
        #1 check_eq("hold_b_mem", ex_src_b, 32'h7);
        check_eq("hold_stall", 32'(id_stall), 1);
        step();
        mem_fwd_valid = 0; wb_fwd_valid = 1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h7;
        #1 check_eq("hold_b_wb", ex_src_b, 32'h7);
        step();
        wb_fwd_valid = 0;
        #1 check_eq("hold_b_ret", ex_src_b, 32'h7);
        step();
        ex_hold = 0;
        #1 check_eq("hold_b_rel", ex_src_b, 32'h7);
        check_eq("hold_valid", 32'(ex_valid), 1);
        check_eq("hold_rd", 32'(ex_rd), 8);

        // Second load-use via store data (rs2 used by mem_write)
        idle();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd7;
        id_a_sel = A_SEL_ZERO; id_b_sel = B_SEL_IMM;
        step();
        idle();
        id_valid = 1; id_mem_write = 1; id_a_sel = A_SEL_REG; id_rs1 = 5'd0;
        id_b_sel = B_SEL_IMM; id_rs2 = 5'd7;
        #1 check_eq("lu2_stall", 32'(id_stall), 1);
        expect_out("lu2_bubble_valid", O_VALID, 0);
        expect_out("lu2_bubble_mw", O_MW, 0);
        step();
        mem_fwd_valid = 1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hBEEF;
        expect_out("lu2_store", O_STORE, 32'hBEEF);
        expect_out("lu2_mw", O_MW, 1);
        expect_out("lu2_valid", O_VALID, 1);
        step();
`ifdef ID_EX_STATS_EN
        check_eq("stat_bubbles", stat_bubbles, 2);
        check_eq("stat_flushes", stat_flushes, 1);
`endif

        // Reset clears the slot and counters
        idle();
        reset = 1;
        expect_out("rst2_valid", O_VALID, 0);
        expect_out("rst2_mw", O_MW, 0);
        step();
`ifdef ID_EX_STATS_EN
        check_eq("rst2_stat_bub", stat_bubbles, 0);
        check_eq("rst2_stat_fl", stat_flushes, 0);
`endif
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
